decap_bank_seq: RTL



---
 rtl/decap_pkg.sv | 28 ++
 rtl/decap_step_timer.sv | 39 +++
 rtl/decap_bank_seq.sv | 129 ++++++++++++
 3 files changed

// File: rtl/decap_pkg.sv
// rtl/decap_pkg.sv - shared types and helpers for the decap bank sequencer
package decap_pkg;

    // Largest bank the thermometer helper can describe
    localparam int MAX_SEG = 64;

    // Sequencer states
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RAMP = 1'b1
    } state_e;

    // Width needed to hold a segment count in 0..n_seg
    function automatic int seg_w(input int n_seg);
        return $clog2(n_seg + 1);
    endfunction

    // Thermometer code: bit i set iff i < n; callers truncate to their bank size
    function automatic logic [MAX_SEG-1:0] therm(input logic [6:0] n);
        logic [MAX_SEG-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_SEG; i++) begin
            v[i] = (i < int'(n));
        end
        return v;
    endfunction

endpackage

// File: rtl/decap_step_timer.sv
// rtl/decap_step_timer.sv - step interval countdown for the decap sequencer
module decap_step_timer
    import decap_pkg::*;
#(
    parameter int STEP_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic clr,
    input  logic en,
    output logic tick
);

    // A one-cycle interval still needs a 1-bit counter that simply sits at zero
    localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [TW-1:0] RELOAD = TW'(STEP_CYCLES - 1);
    localparam logic [TW-1:0] ONE    = TW'(1);

    logic [TW-1:0] count_q;

    assign tick = en && (count_q == '0);

    // Countdown: clear wins over load, load wins over counting; wraps to RELOAD on tick
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= RELOAD;
        end else if (en) begin
            if (count_q == '0) begin
                count_q <= RELOAD;
            end else begin
                count_q <= count_q - ONE;
            end
        end
    end

endmodule

// File: rtl/decap_bank_seq.sv
// rtl/decap_bank_seq.sv - one-segment-at-a-time sequencer for a switchable decap bank
module decap_bank_seq
    import decap_pkg::*;
#(
    parameter int N_SEG       = 8,
    parameter int STEP_CYCLES = 4,
    parameter int SEG_W       = seg_w(N_SEG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [SEG_W-1:0] tgt,
    input  logic             abort,
    output logic [N_SEG-1:0] seg_en,
    output logic [SEG_W-1:0] cur,
    output logic             busy,
    output logic             done,
    output logic             tie_hi,
    output logic             tie_lo
);

    localparam logic [SEG_W-1:0] N_SEG_W = SEG_W'(N_SEG);
    localparam logic [SEG_W-1:0] ONE     = SEG_W'(1);

    state_e           state_q;
    logic [SEG_W-1:0] cur_q;
    logic [SEG_W-1:0] tgt_q;
    logic             busy_q;
    logic             done_q;
    logic             tie_hi_q;

    logic [SEG_W-1:0] tgt_c;
    logic [SEG_W-1:0] tgt_eff;
    logic [SEG_W-1:0] cur_d;
    logic             tick;
    logic             timer_load;
    logic             timer_clr;
    logic             timer_en;

    // Clamp the request, pick the target the next step heads for, and form the stepped count
    always_comb begin
        tgt_c   = (tgt > N_SEG_W) ? N_SEG_W : tgt;
        tgt_eff = go ? tgt_c : tgt_q;
        cur_d   = (tgt_eff > cur_q) ? (cur_q + ONE) : (cur_q - ONE);
    end

    // The timer restarts only when a ramp starts from idle; a retarget keeps the cadence
    always_comb begin
        timer_clr  = abort;
        timer_load = (state_q == S_IDLE) && go && (tgt_c != cur_q);
        timer_en   = (state_q == S_RAMP);
    end

    decap_step_timer #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load),
        .clr  (timer_clr),
        .en   (timer_en),
        .tick (tick)
    );

    // Sequencer FSM with target latch, segment counter and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cur_q    <= '0;
            tgt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tie_hi_q <= 1'b0;
        end else begin
            tie_hi_q <= 1'b1;
            done_q   <= 1'b0;
            if (abort) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (go) begin
                            if (tgt_c != cur_q) begin
                                tgt_q   <= tgt_c;
                                state_q <= S_RAMP;
                                busy_q  <= 1'b1;
                            end else begin
                                done_q <= 1'b1;
                            end
                        end
                    end
                    S_RAMP: begin
                        if (go && (tgt_c == cur_q)) begin
                            tgt_q   <= tgt_c;
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            if (go) begin
                                tgt_q <= tgt_c;
                            end
                            if (tick) begin
                                cur_q <= cur_d;
                                if (cur_d == tgt_eff) begin
                                    state_q <= S_IDLE;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign seg_en = N_SEG'(therm(7'(cur_q)));
    assign cur    = cur_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign tie_hi = tie_hi_q;
    assign tie_lo = 1'b0;

endmodule
